// File: rtl/trade_order_unit_pkg.sv
// Shared types and constants for the trade order unit (package trade_pkg).
package trade_pkg;
  typedef enum logic [1:0] {TLU_IDLE, TLU_SEND, TLU_COOLDOWN} tlu_state_t;

  localparam logic SIDE_BUY  = 1'b0;
  localparam logic SIDE_SELL = 1'b1;
endpackage

// File: rtl/trade_order_unit_if.sv
// Order port: valid/ready handshake carrying side, quantity and limit price.
// The order producer (trade_order_unit) uses master; the downstream consumer uses slave.
interface trade_order_unit_if #(
  parameter int DATA_WIDTH = 16,
  parameter int POS_WIDTH  = 8
);
  logic                  order_valid;
  logic                  order_ready;
  logic                  order_side;
  logic [POS_WIDTH-1:0]  order_qty;
  logic [DATA_WIDTH-1:0] order_price;

  modport master (
    output order_valid, order_side, order_qty, order_price,
    input  order_ready
  );

  modport slave (
    input  order_valid, order_side, order_qty, order_price,
    output order_ready
  );
endinterface

// File: rtl/trade_order_unit_cooldown.sv
// Post-fill cooldown timer: load on fill, count down while enabled, done at zero.
module tlu_cooldown_timer #(
  parameter int CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic done
);
  localparam int CW = (CYC > 1) ? $clog2(CYC) : 1;
  localparam logic [CW-1:0] LOAD_VAL = (CYC > 0) ? CW'(CYC - 1) : '0;

  logic [CW-1:0] cnt;

  // Load CYC-1 so that exactly CYC cooldown cycles elapse before done is seen.
  always_ff @(posedge clk) begin
    if (rst)                  cnt <= '0;
    else if (load)            cnt <= LOAD_VAL;
    else if (en && cnt != '0) cnt <= cnt - 1'b1;
  end

  assign done = (cnt == '0);
endmodule

// File: rtl/trade_order_unit.sv
// Trade logic unit: turns strategy buy/sell pulses into one outstanding order,
// enforcing a position limit and a post-fill cooldown, and tracking net position.
// Optional build macro: TLU_STOP_LOSS_EN adds entry-price tracking and a
// forced flatten order when price moves adversely by more than STOP_LOSS.
module trade_order_unit
  import trade_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int POS_WIDTH    = 8,
  parameter int LOT          = 1,
  parameter int MAX_POS      = 4,
  parameter int COOLDOWN_CYC = 4,
  parameter int STOP_LOSS    = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        data_valid_mean,
  input  logic                        buy_signal,
  input  logic                        sell_signal,
  input  logic [DATA_WIDTH-1:0]       price,
  trade_order_unit_if.master          ord,
  output logic signed [POS_WIDTH-1:0] position,
  output logic                        busy,
  output logic [7:0]                  drop_cnt
);
  // Parameter sanity: the limit must leave headroom in the signed position.
  if (MAX_POS > (2 ** (POS_WIDTH - 1)) - 1 || STOP_LOSS < 0) begin : g_bad_param
    $error("trade_order_unit: bad MAX_POS/STOP_LOSS");
  end

  localparam logic signed [POS_WIDTH:0] P_MAX = (POS_WIDTH + 1)'(MAX_POS);
  localparam logic signed [POS_WIDTH:0] P_LOT = (POS_WIDTH + 1)'(LOT);

  tlu_state_t state, state_nx;

  logic                        side_q;
  logic [POS_WIDTH-1:0]        qty_q;
  logic [DATA_WIDTH-1:0]       price_q;
  logic signed [POS_WIDTH-1:0] pos_q, pos_next;
  logic [7:0]                  drop_q;
  logic signed [POS_WIDTH:0]   pos_w;
  logic buy_ok, sell_ok, sig_one, sig_accept, accept, drop, fill, flatten, cd_done;

  logic                        flat_side;
  logic [POS_WIDTH-1:0]        flat_qty;

  // Limit checks are one bit wider than the position so they cannot wrap.
  assign pos_w      = {pos_q[POS_WIDTH-1], pos_q};
  assign buy_ok     = (pos_w + P_LOT) <= P_MAX;
  assign sell_ok    = (pos_w - P_LOT) >= -P_MAX;
  assign sig_one    = data_valid_mean & (buy_signal ^ sell_signal);
  assign sig_accept = (state == TLU_IDLE) & ~flatten & sig_one & (buy_signal ? buy_ok : sell_ok);
  assign accept     = sig_accept | flatten;
  assign drop       = sig_one & ~sig_accept;
  assign fill       = (state == TLU_SEND) & ord.order_ready;
  assign pos_next   = (side_q == SIDE_SELL) ? pos_q - $signed(qty_q) : pos_q + $signed(qty_q);

`ifdef TLU_STOP_LOSS_EN
  logic [DATA_WIDTH-1:0] entry_price;
  logic [DATA_WIDTH:0]   px_w, entry_w, sl_w;
  logic                  is_long, is_short;

  function automatic logic [POS_WIDTH-1:0] abs_p(input logic signed [POS_WIDTH-1:0] v);
    return v[POS_WIDTH-1] ? POS_WIDTH'(-v) : POS_WIDTH'(v);
  endfunction

  assign px_w      = {1'b0, price};
  assign entry_w   = {1'b0, entry_price};
  assign sl_w      = (DATA_WIDTH + 1)'(STOP_LOSS);
  assign is_short  = pos_q[POS_WIDTH-1];
  assign is_long   = ~is_short & (pos_q != '0);
  assign flatten   = (state == TLU_IDLE) & data_valid_mean &
                     ((is_long & (px_w + sl_w < entry_w)) | (is_short & (px_w > entry_w + sl_w)));
  assign flat_side = is_short ? SIDE_BUY : SIDE_SELL;
  assign flat_qty  = abs_p(pos_q);

  // Entry price follows fills that grow the exposure and clears when flat.
  always_ff @(posedge clk) begin
    if (rst)                                   entry_price <= '0;
    else if (fill && pos_next == '0)           entry_price <= '0;
    else if (fill && abs_p(pos_next) > abs_p(pos_q)) entry_price <= price_q;
  end
`else
  assign flatten   = 1'b0;
  assign flat_side = SIDE_BUY;
  assign flat_qty  = '0;
`endif

  tlu_cooldown_timer #(.CYC(COOLDOWN_CYC)) u_cooldown (
    .clk  (clk),
    .rst  (rst),
    .load (fill),
    .en   (state == TLU_COOLDOWN),
    .done (cd_done)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= TLU_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      TLU_IDLE:     if (accept) state_nx = TLU_SEND;
      TLU_SEND:     if (fill)   state_nx = (COOLDOWN_CYC > 0) ? TLU_COOLDOWN : TLU_IDLE;
      TLU_COOLDOWN: if (cd_done) state_nx = TLU_IDLE;
      default:      state_nx = TLU_IDLE;
    endcase
  end

  // Output decode from state and held order fields.
  always_comb begin
    ord.order_valid = (state == TLU_SEND);
    ord.order_side  = side_q;
    ord.order_qty   = qty_q;
    ord.order_price = price_q;
    busy            = (state != TLU_IDLE);
    position        = pos_q;
    drop_cnt        = drop_q;
  end

  // Order fields latch on accept and stay put until the next accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      side_q  <= SIDE_BUY;
      qty_q   <= '0;
      price_q <= '0;
    end else if (accept) begin
      side_q  <= flatten ? flat_side : (sell_signal ? SIDE_SELL : SIDE_BUY);
      qty_q   <= flatten ? flat_qty : POS_WIDTH'(LOT);
      price_q <= price;
    end
  end

  // Net position moves only on the handshake edge.
  always_ff @(posedge clk) begin
    if (rst)       pos_q <= '0;
    else if (fill) pos_q <= pos_next;
  end

  // Saturating count of single-sided signals that were not acted on.
  always_ff @(posedge clk) begin
    if (rst)                          drop_q <= '0;
    else if (drop && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
  end
endmodule
